// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - step-driven operand/operation sequencer for an external combinational ALU
module alu_sequencer (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       step,
    input  logic       clr,
    input  logic       acc,
    input  logic [2:0] din,
    input  logic [1:0] op_sel,
    input  logic [3:0] alu_res,
    input  logic       alu_flag,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_op,
    output logic [3:0] result,
    output logic       flag,
    output logic [2:0] state,
    output logic       busy,
    output logic       done,
    output logic [3:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_B = 3'd1,
        S_EXEC   = 3'd2,
        S_DONE   = 3'd3,
        S_SHOW   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       step_q, step_d;
    // armed_q blocks a rise until step has been seen low since reset,
    // so a switch left high across reset release does not start an operation.
    logic       armed_q, armed_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [3:0] result_q, result_d;
    logic       flag_q, flag_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] count_q, count_d;
    logic       rise;

    // Next-state, operand capture and registered-output computation
    always_comb begin
        rise     = step & ~step_q & armed_q;
        step_d   = step;
        armed_d  = armed_q | ~step;
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flag_d   = flag_q;
        count_d  = count_q;

        if (clr) begin
            // clear wins over a coincident rise; op_count is deliberately kept
            state_d  = S_IDLE;
            a_d      = 3'd0;
            b_d      = 3'd0;
            op_d     = 2'd0;
            result_d = 4'd0;
            flag_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        a_d     = din;
                        state_d = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (rise) begin
                        b_d     = din;
                        op_d    = op_sel;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // operands are stable here, so the ALU output is settled
                    result_d = alu_res;
                    flag_d   = alu_flag;
                    if (count_q != 4'd15) begin
                        count_d = count_q + 4'd1;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (rise) begin
                        a_d     = acc ? result_q[2:0] : din;
                        state_d = S_WAIT_B;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_EXEC) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State register with asynchronous abort on reset
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= 1'b0;
            armed_q  <= 1'b0;
            a_q      <= 3'd0;
            b_q      <= 3'd0;
            op_q     <= 2'd0;
            result_q <= 4'd0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            armed_q  <= armed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign result   = result_q;
    assign flag     = flag_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign op_count = count_q;

endmodule
